// File: rtl/line_prefetch_ctrl_if.sv
// Bundle of the scan-timing, memory-controller and pixel signals around
// line_prefetch_ctrl. The controller connects through the master modport;
// the surrounding system (timing generator, memory controller, colour mapper)
// uses the slave modport.
interface line_prefetch_ctrl_if #(
    parameter int PIXELS = 848,
    parameter int BPP    = 2,
    parameter int ROW_W  = 9
);
    logic                     newLine;
    logic                     active;
    logic [ROW_W-1:0]         VCount;
    logic                     memStart;
    logic                     memWrite;
    logic [ROW_W-1:0]         memRow;
    logic [PIXELS*BPP-1:0]    memData;
    logic                     memDone;
    logic [BPP-1:0]           pixel;
    logic                     pixelValid;
    logic                     underrun;
    logic                     fetchBusy;

    modport master (
        input  newLine, active, VCount, memData, memDone,
        output memStart, memWrite, memRow, pixel, pixelValid, underrun, fetchBusy
    );

    modport slave (
        output newLine, active, VCount, memData, memDone,
        input  memStart, memWrite, memRow, pixel, pixelValid, underrun, fetchBusy
    );
endinterface

// File: rtl/line_prefetch_ctrl.sv
// Line-buffered scan-out stage. At every line boundary the prefetched back
// line becomes the front line and the following row is requested from SDRAM.
// The front line is serialised into BPP-bit pixel codes while the horizontal
// window is active; a boundary that finds no completed fetch zero-fills the
// front line and raises a one-cycle underrun pulse.
module line_prefetch_ctrl #(
    parameter int PIXELS  = 848,
    parameter int BPP     = 2,
    parameter int ROWS    = 512,
    parameter int TIMEOUT = 1024,
    parameter int ROW_W   = 9
) (
    input  logic                CLK,
    input  logic                Reset,
    line_prefetch_ctrl_if.master bus
);

    localparam int LINE_W   = PIXELS * BPP;
    localparam int IDX_W    = $clog2(PIXELS);
    localparam int BASE_W   = $clog2(LINE_W);
    localparam int TMR_W    = $clog2(TIMEOUT);
    localparam int IDX_LAST = PIXELS - 1;
    localparam int TMR_LAST = TIMEOUT - 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_LOW,
        WAIT_DONE,
        READY
    } state_t;

    state_t              state_q,      state_d;
    logic [TMR_W-1:0]    timer_q,      timer_d;
    logic [ROW_W-1:0]    memRow_q,     memRow_d;
    logic [LINE_W-1:0]   front_q,      front_d;
    logic [LINE_W-1:0]   back_q,       back_d;
    logic                backValid_q,  backValid_d;
    logic                underrun_q,   underrun_d;
    logic [IDX_W-1:0]    pixIdx_q,     pixIdx_d;
    logic [BPP-1:0]      pixel_q,      pixel_d;
    logic                pixelValid_q, pixelValid_d;
    logic [BASE_W-1:0]   pix_base;

    // Row following v, wrapping to 0 when it reaches the row modulus.
    function automatic logic [ROW_W-1:0] next_row(input logic [ROW_W-1:0] v);
        logic [ROW_W:0] n;
        n = {1'b0, v} + 1'b1;
        if (n == ROWS[ROW_W:0])
            return '0;
        return n[ROW_W-1:0];
    endfunction

    assign pix_base = BASE_W'(pixIdx_q) * BASE_W'(BPP);

    // Fetch FSM next state, back/front line handling and line-boundary swap.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        memRow_d    = memRow_q;
        front_d     = front_q;
        back_d      = back_q;
        backValid_d = backValid_q;
        underrun_d  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            REQ: begin
                // memStart is high for this single cycle; the timer starts fresh.
                timer_d = '0;
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // A Done still high from the previous operation must drop first.
                if (timer_q == TMR_LAST[TMR_W-1:0]) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (!bus.memDone)
                        state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Timeout wins over a completion arriving on the same cycle.
                if (timer_q == TMR_LAST[TMR_W-1:0]) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (bus.memDone) begin
                        back_d      = bus.memData;
                        backValid_d = 1'b1;
                        state_d     = READY;
                    end
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The boundary overrides everything, including a completion this cycle:
        // a fetch not yet marked valid is discarded and restarted.
        if (bus.newLine) begin
            front_d     = backValid_q ? back_q : '0;
            underrun_d  = ~backValid_q;
            backValid_d = 1'b0;
            memRow_d    = next_row(bus.VCount);
            state_d     = REQ;
        end
    end

    // Pixel serialiser: one code per active cycle, index saturating at the line end.
    always_comb begin
        pixel_d      = '0;
        pixelValid_d = 1'b0;
        pixIdx_d     = pixIdx_q;

        if (bus.active) begin
            pixel_d      = front_q[pix_base +: BPP];
            pixelValid_d = 1'b1;
            if (pixIdx_q != IDX_LAST[IDX_W-1:0])
                pixIdx_d = pixIdx_q + 1'b1;
        end

        if (bus.newLine)
            pixIdx_d = '0;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            memRow_q     <= '0;
            front_q      <= '0;
            back_q       <= '0;
            backValid_q  <= 1'b0;
            underrun_q   <= 1'b0;
            pixIdx_q     <= '0;
            pixel_q      <= '0;
            pixelValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            memRow_q     <= memRow_d;
            front_q      <= front_d;
            back_q       <= back_d;
            backValid_q  <= backValid_d;
            underrun_q   <= underrun_d;
            pixIdx_q     <= pixIdx_d;
            pixel_q      <= pixel_d;
            pixelValid_q <= pixelValid_d;
        end
    end

    assign bus.memStart   = (state_q == REQ);
    assign bus.memWrite   = 1'b0;
    assign bus.memRow     = memRow_q;
    assign bus.pixel      = pixel_q;
    assign bus.pixelValid = pixelValid_q;
    assign bus.underrun   = underrun_q;
    assign bus.fetchBusy  = (state_q == REQ) || (state_q == WAIT_LOW) || (state_q == WAIT_DONE);

endmodule
